// File: rtl/dcache_control.sv
// rtl/dcache_control.sv - sequencing FSM and saturating perf counters for the direct-mapped data cache
module dcache_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit,
  input  logic                 dirty_out,
  output logic                 tag_load,
  output logic                 valid_load,
  output logic                 dirty_load,
  output logic                 dirty_in,
  output logic [1:0]           writing,
  input  logic                 perf_clear,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  localparam logic [1:0] WR_FILL = 2'b00;
  localparam logic [1:0] WR_CPU  = 2'b01;
  localparam logic [1:0] WR_HOLD = 2'b10;

  state_t               r_state;
  state_t               w_next;
  logic                 r_refill;
  logic                 w_refill_next;
  logic                 w_req;
  logic                 w_hit_inc;
  logic                 w_miss_inc;
  logic                 w_wb_inc;
  logic [CNT_WIDTH-1:0] r_hit_count;
  logic [CNT_WIDTH-1:0] r_miss_count;
  logic [CNT_WIDTH-1:0] r_wb_count;

  // A simultaneous read and write is handled as a write by keying on mem_write below.
  assign w_req = mem_read | mem_write;

  // State register and refill flag; the flag marks the re-compare after a fill so it is not counted as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_refill <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_refill <= w_refill_next;
    end
  end

  // Next-state logic, datapath controls, pmem handshake and counter strobes.
  always_comb begin
    w_next        = r_state;
    w_refill_next = r_refill;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    dirty_load    = 1'b0;
    dirty_in      = 1'b0;
    writing       = WR_HOLD;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    w_wb_inc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (!w_req) begin
          // Request abandoned during a miss: finish quietly without a response.
          w_next        = S_IDLE;
          w_refill_next = 1'b0;
        end else if (hit) begin
          mem_resp      = 1'b1;
          w_next        = S_IDLE;
          w_refill_next = 1'b0;
          w_hit_inc     = ~r_refill;
          if (mem_write) begin
            writing    = WR_CPU;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end else begin
          w_miss_inc    = ~r_refill;
          w_refill_next = 1'b1;
          w_next        = dirty_out ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          // Clearing dirty switches the datapath's pmem address to the request tag for the fill.
          dirty_load = 1'b1;
          w_wb_inc   = 1'b1;
          w_next     = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          writing    = WR_FILL;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          w_next     = S_COMPARE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Saturating performance counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clear) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (w_hit_inc && (r_hit_count != '1))   r_hit_count  <= r_hit_count + CNT_WIDTH'(1);
      if (w_miss_inc && (r_miss_count != '1)) r_miss_count <= r_miss_count + CNT_WIDTH'(1);
      if (w_wb_inc && (r_wb_count != '1))     r_wb_count   <= r_wb_count + CNT_WIDTH'(1);
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_dcache_control.sv
// tb/tb_dcache_control.sv - self-checking bench for dcache_control against a behavioural cache model
module tb_dcache_control;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp;
  logic          hit;
  logic          dirty_out;
  logic          tag_load;
  logic          valid_load;
  logic          dirty_load;
  logic          dirty_in;
  logic [1:0]    writing;
  logic          perf_clear;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] wb_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural datapath/cache state and expected counter values
  bit m_valid [8];
  int m_tag   [8];
  bit m_dirty [8];
  int e_hit, e_miss, e_wb;

  dcache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit(hit), .dirty_out(dirty_out), .tag_load(tag_load), .valid_load(valid_load),
    .dirty_load(dirty_load), .dirty_in(dirty_in), .writing(writing), .perf_clear(perf_clear),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= MAX) ? MAX : v + 1;
  endfunction

  function automatic logic [8:0] ev(input bit mr, input bit pr, input bit pw, input bit tl,
                                    input bit vl, input bit dl, input bit di, input logic [1:0] wr);
    return {mr, pr, pw, tl, vl, dl, di, wr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [8:0] exp);
    chk(tag, {23'd0, mem_resp, pmem_read, pmem_write, tag_load, valid_load,
              dirty_load, dirty_in, writing}, {23'd0, exp});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit"},  {28'd0, hit_count},  e_hit);
    chk({tag, "_miss"}, {28'd0, miss_count}, e_miss);
    chk({tag, "_wb"},   {28'd0, wb_count},   e_wb);
  endtask

  // One complete CPU transaction; expected behaviour follows from the cache contents alone.
  task automatic run_req(input bit rd, input bit wr, input int set, input int tag,
                         input int wl, input int rl, input bit clr);
    bit eh, ewb;
    logic [1:0] wsel;
    wsel = wr ? 2'b01 : 2'b10;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    hit       = m_valid[set] && (m_tag[set] == tag);
    dirty_out = m_dirty[set];
    eh        = hit;
    ewb       = !hit && m_dirty[set];
    #1 chk_outs("idle_req", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
    @(negedge clk);
    if (eh) begin
      perf_clear = clr;
      #1 chk_outs("cmp_hit", ev(1, 0, 0, 0, 0, wr, wr, wsel));
      if (wr) m_dirty[set] = 1'b1;
      e_hit = sat(e_hit);
    end else begin
      #1 chk_outs("cmp_miss", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
      e_miss = sat(e_miss);
      if (ewb) begin
        for (int k = 1; k <= wl; k++) begin
          @(negedge clk);
          pmem_resp = (k == wl);
          #1 chk_outs("writeback", ev(0, 0, 1, 0, 0, k == wl, 0, 2'b10));
        end
        m_dirty[set] = 1'b0;
        dirty_out    = 1'b0;
        e_wb         = sat(e_wb);
      end
      for (int k = 1; k <= rl; k++) begin
        @(negedge clk);
        pmem_resp = (k == rl);
        #1 chk_outs("allocate", ev(0, 1, 0, k == rl, k == rl, k == rl, 0, (k == rl) ? 2'b00 : 2'b10));
      end
      m_valid[set] = 1'b1;
      m_tag[set]   = tag;
      m_dirty[set] = 1'b0;
      @(negedge clk);
      pmem_resp  = 1'b0;
      hit        = 1'b1;
      dirty_out  = 1'b0;
      perf_clear = clr;
      #1 chk_outs("cmp_fill", ev(1, 0, 0, 0, 0, wr, wr, wsel));
      if (wr) m_dirty[set] = 1'b1;
    end
    if (clr) begin
      e_hit = 0; e_miss = 0; e_wb = 0;
    end
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    perf_clear = 1'b0;
    hit        = 1'b0;
    #1 chk_outs("back_idle", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
    chk_cnt("cnt");
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit = 1'b0; dirty_out = 1'b0; perf_clear = 1'b0;
    e_hit = 0; e_miss = 0; e_wb = 0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_dirty[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1 chk_outs("reset_outs", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
    chk_cnt("reset_cnt");
    rst = 1'b0;

    // Clean miss with pmem latency 5, then read hit, write hit, dirty miss with tag change
    run_req(1, 0, 0, 1, 0, 5, 0);
    run_req(1, 0, 0, 1, 0, 0, 0);
    run_req(0, 1, 0, 1, 0, 0, 0);
    run_req(1, 0, 0, 2, 3, 4, 0);

    // Reset during the third ALLOCATE wait cycle
    @(negedge clk);
    mem_read = 1'b1; hit = 1'b0; dirty_out = 1'b0;
    #1 chk_outs("rst_idle", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
    @(negedge clk);
    #1 chk_outs("rst_cmp", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b1;
      #1 chk_outs("rst_wait", ev(0, 1, 0, 0, 0, 0, 0, 2'b10));
    end
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    e_hit = 0; e_miss = 0; e_wb = 0;
    #1 chk_outs("rst_dropped", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
    chk_cnt("rst_cnt");
    @(negedge clk);
    pmem_resp = 1'b1;
    #1 chk_outs("late_resp", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));
    @(negedge clk);
    pmem_resp = 1'b0;
    #1 chk_outs("after_late", ev(0, 0, 0, 0, 0, 0, 0, 2'b10));

    // Saturation at 15 after 17 hits, then clear coinciding with a hit
    for (int i = 0; i < 17; i++) run_req(1, 0, 0, 2, 0, 0, 0);
    chk("sat_hit", {28'd0, hit_count}, MAX);
    run_req(1, 0, 0, 2, 0, 0, 1);

    // Simultaneous read and write behaves as a write
    run_req(1, 1, 3, 1, 2, 2, 0);

    // Randomised traffic against the cache model
    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      run_req(mode != 1, mode != 0, $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(1, 4), $urandom_range(1, 4), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
